// File: rtl/video_dnn_count_frame_ctl_pkg.sv
// Shared types and helpers for the DNN class-count frame controller.
//   main_state_t : frame FSM states (IDLE, WAIT_SOF, ACCUM)
//   scan_state_t : argmax scan FSM states (S_IDLE, S_SCAN, S_OUT)
//   sat_add      : unsigned add that clamps at 2^width-1 instead of wrapping
package video_dnn_count_pkg;

    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACCUM    = 2'd2
    } main_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_OUT  = 2'd2
    } scan_state_t;

    // Operands are zero-extended to SAT_W by the caller; the result is
    // clamped to the all-ones value of a 'width'-bit accumulator.
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int               width);
        logic [SAT_W:0] sum_v;
        logic [SAT_W:0] lim_v;
        sum_v = {1'b0, a} + {1'b0, b};
        lim_v = ({{SAT_W{1'b0}}, 1'b1} << width) - {{SAT_W{1'b0}}, 1'b1};
        if (sum_v > lim_v) begin
            sat_add = lim_v[SAT_W-1:0];
        end else begin
            sat_add = sum_v[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/video_dnn_count_frame_ctl_if.sv
// Bus bundles for the frame controller.
//   video_dnn_count_stream_if : per-pixel class-count stream (tuser[0]=SOF,
//                               tlast=EOL, tcount, tvalid, tready)
//   video_dnn_count_result_if : frame result (m_class, m_max, m_sum,
//                               m_valid, m_ready)
interface video_dnn_count_stream_if #(
    parameter int NUM_CLASS   = 10,
    parameter int COUNT_WIDTH = 3,
    parameter int TUSER_WIDTH = 1
);
    logic [TUSER_WIDTH-1:0]           s_axi4s_tuser;
    logic                             s_axi4s_tlast;
    logic [NUM_CLASS*COUNT_WIDTH-1:0] s_axi4s_tcount;
    logic                             s_axi4s_tvalid;
    logic                             s_axi4s_tready;

    modport master (output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tcount, s_axi4s_tvalid,
                    input  s_axi4s_tready);
    modport slave  (input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tcount, s_axi4s_tvalid,
                    output s_axi4s_tready);
endinterface

interface video_dnn_count_result_if #(
    parameter int NUM_CLASS   = 10,
    parameter int SUM_WIDTH   = 24,
    parameter int CLASS_WIDTH = 4
);
    logic [CLASS_WIDTH-1:0]         m_class;
    logic [SUM_WIDTH-1:0]           m_max;
    logic [NUM_CLASS*SUM_WIDTH-1:0] m_sum;
    logic                           m_valid;
    logic                           m_ready;

    modport master (output m_class, m_max, m_sum, m_valid, input m_ready);
    modport slave  (input  m_class, m_max, m_sum, m_valid, output m_ready);
endinterface

// File: rtl/video_dnn_count_frame_ctl_argmax_seq.sv
// Sequential argmax over a snapshot of the per-class frame totals.
//   clk, reset, cke : clock, async active-high reset, clock enable
//   start           : frame end this cycle; rslt holds the final totals
//   rslt            : per-class totals, class i at [i*SUM_WIDTH +: SUM_WIDTH]
//   busy            : scan or output pending (start is ignored while set)
//   m_rslt          : result port, held stable until m_valid && m_ready
module video_dnn_count_argmax_seq
    import video_dnn_count_pkg::*;
#(
    parameter int NUM_CLASS   = 10,
    parameter int SUM_WIDTH   = 24,
    parameter int CLASS_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cke,
    input  logic                           start,
    input  logic [NUM_CLASS*SUM_WIDTH-1:0] rslt,
    output logic                           busy,
    video_dnn_count_result_if.master       m_rslt
);

    scan_state_t                    state_r;
    logic [CLASS_WIDTH-1:0]         idx_r;
    logic [CLASS_WIDTH-1:0]         class_r;
    logic [SUM_WIDTH-1:0]           best_r;
    logic [NUM_CLASS*SUM_WIDTH-1:0] rslt_r;
    logic                           valid_r;
    logic                           busy_r;
    logic [SUM_WIDTH-1:0]           cand_s;
    logic                           last_s;

    assign cand_s = rslt_r[idx_r*SUM_WIDTH +: SUM_WIDTH];
    assign last_s = (idx_r == CLASS_WIDTH'(NUM_CLASS - 1));

    // Scan FSM: snapshot on start, one class per cycle, hold result until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            idx_r   <= '0;
            class_r <= '0;
            best_r  <= '0;
            rslt_r  <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else if (cke) begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r <= S_SCAN;
                        busy_r  <= 1'b1;
                        rslt_r  <= rslt;
                        idx_r   <= '0;
                        class_r <= '0;
                        best_r  <= rslt[SUM_WIDTH-1:0];
                    end
                end
                S_SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (cand_s > best_r) begin
                        best_r  <= cand_s;
                        class_r <= idx_r;
                    end
                    if (last_s) begin
                        state_r <= S_OUT;
                        valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + CLASS_WIDTH'(1);
                    end
                end
                S_OUT: begin
                    if (m_rslt.m_ready) begin
                        state_r <= S_IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign m_rslt.m_class = class_r;
    assign m_rslt.m_max   = best_r;
    assign m_rslt.m_sum   = rslt_r;
    assign m_rslt.m_valid = valid_r;

endmodule

// File: rtl/video_dnn_count_frame_ctl.sv
// Frame-level collector for the per-pixel DNN class counter. Accumulates
// per-class totals over a frame (SOF on tuser[0], lines on tlast, height
// from param_height), then hands the totals to a sequential argmax.
//   reset, clk, cke  : async active-high reset, clock, global clock enable
//   ctl_enable       : 1 = run, 0 = return to IDLE discarding the partial frame
//   param_height     : lines per frame (>= 1)
//   s_axi4s          : pixel count stream; tready is always 1
//   m_rslt           : winning class, its total and all totals (valid/ready)
//   stat_busy        : frame FSM not IDLE
//   stat_err_count   : short frames seen (saturating)
//   stat_drop_count  : results dropped because the scan was busy (saturating)
module video_dnn_count_frame_ctl
    import video_dnn_count_pkg::*;
#(
    parameter int NUM_CLASS   = 10,
    parameter int COUNT_WIDTH = 3,
    parameter int TUSER_WIDTH = 1,
    parameter int SUM_WIDTH   = 24,
    parameter int Y_WIDTH     = 12,
    parameter int CLASS_WIDTH = 4
) (
    input  logic                      reset,
    input  logic                      clk,
    input  logic                      cke,
    input  logic                      ctl_enable,
    input  logic [Y_WIDTH-1:0]        param_height,
    video_dnn_count_stream_if.slave   s_axi4s,
    video_dnn_count_result_if.master  m_rslt,
    output logic                      stat_busy,
    output logic [7:0]                stat_err_count,
    output logic [7:0]                stat_drop_count
);

    main_state_t                    state_r;
    logic [NUM_CLASS*SUM_WIDTH-1:0] sum_r;
    logic [Y_WIDTH-1:0]             line_r;
    logic                           busy_r;
    logic [7:0]                     err_r;
    logic [7:0]                     drop_r;

    logic [TUSER_WIDTH-1:0]         tuser_s;
    logic                           beat_s;
    logic                           sof_s;
    logic                           last_s;
    logic                           open_s;
    logic                           h1_s;
    logic [Y_WIDTH-1:0]             line_inc_s;
    logic                           frame_end_s;
    logic                           scan_busy_s;
    logic [NUM_CLASS*SUM_WIDTH-1:0] init_s;
    logic [NUM_CLASS*SUM_WIDTH-1:0] acc_s;
    logic [NUM_CLASS*SUM_WIDTH-1:0] rslt_s;

    assign s_axi4s.s_axi4s_tready = 1'b1;

    assign tuser_s    = s_axi4s.s_axi4s_tuser;
    assign sof_s      = tuser_s[0];
    assign last_s     = s_axi4s.s_axi4s_tlast;
    assign beat_s     = cke && s_axi4s.s_axi4s_tvalid;
    assign open_s     = (state_r == WAIT_SOF) || (state_r == ACCUM);
    assign h1_s       = (param_height == Y_WIDTH'(1));
    assign line_inc_s = line_r + Y_WIDTH'(1);

    // An SOF beat (from WAIT_SOF or as a short-frame restart) ends the frame
    // on its own only when the frame is one line tall.
    assign frame_end_s = beat_s && ctl_enable && last_s &&
                         ((sof_s && open_s && h1_s) ||
                          (!sof_s && (state_r == ACCUM) && (line_inc_s == param_height)));
    assign rslt_s = sof_s ? init_s : acc_s;

    // Per-class start value (SOF beat) and saturating running sum (other beats).
    always_comb begin
        init_s = '0;
        acc_s  = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            init_s[i*SUM_WIDTH +: SUM_WIDTH] =
                SUM_WIDTH'(s_axi4s.s_axi4s_tcount[i*COUNT_WIDTH +: COUNT_WIDTH]);
            acc_s[i*SUM_WIDTH +: SUM_WIDTH] = SUM_WIDTH'(sat_add(
                SAT_W'(sum_r[i*SUM_WIDTH +: SUM_WIDTH]),
                SAT_W'(s_axi4s.s_axi4s_tcount[i*COUNT_WIDTH +: COUNT_WIDTH]),
                SUM_WIDTH));
        end
    end

    // Frame FSM with accumulators, line counter, busy flag and short-frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            sum_r   <= '0;
            line_r  <= '0;
            busy_r  <= 1'b0;
            err_r   <= 8'd0;
        end else if (cke) begin
            if (!ctl_enable) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= WAIT_SOF;
                        busy_r  <= 1'b1;
                    end
                    WAIT_SOF, ACCUM: begin
                        if (s_axi4s.s_axi4s_tvalid && sof_s) begin
                            sum_r  <= init_s;
                            line_r <= last_s ? Y_WIDTH'(1) : Y_WIDTH'(0);
                            state_r <= (last_s && h1_s) ? WAIT_SOF : ACCUM;
                            if ((state_r == ACCUM) && (err_r != 8'hFF)) begin
                                err_r <= err_r + 8'd1;
                            end
                        end else if (s_axi4s.s_axi4s_tvalid && (state_r == ACCUM)) begin
                            sum_r <= acc_s;
                            if (last_s) begin
                                line_r <= line_inc_s;
                                if (line_inc_s == param_height) begin
                                    state_r <= WAIT_SOF;
                                end
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Count frame ends that find the scan still working or holding a result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_r <= 8'd0;
        end else if (cke && frame_end_s && scan_busy_s && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
        end
    end

    video_dnn_count_argmax_seq #(
        .NUM_CLASS   (NUM_CLASS),
        .SUM_WIDTH   (SUM_WIDTH),
        .CLASS_WIDTH (CLASS_WIDTH)
    ) u_argmax (
        .clk    (clk),
        .reset  (reset),
        .cke    (cke),
        .start  (frame_end_s),
        .rslt   (rslt_s),
        .busy   (scan_busy_s),
        .m_rslt (m_rslt)
    );

    assign stat_busy       = busy_r;
    assign stat_err_count  = err_r;
    assign stat_drop_count = drop_r;

endmodule

// File: doc/video_dnn_count_frame_ctl.md
Name: video_dnn_count_frame_ctl

Overview:
- Frame-level scheduler and collector behind the per-pixel DNN class counter.
- Consumes the pixel stream of per-class counts and accumulates a per-class total over each frame, framing on tuser[0] (SOF) and tlast (EOL) with a programmed height.
- At frame end it snapshots the totals and runs a sequential argmax scan, one class per cycle.
- Presents the winning class plus all totals on a valid/ready result port for the register block or OLED overlay. Never stalls video.

Parameters:
- NUM_CLASS, 10, number of classes.
- COUNT_WIDTH, 3, width of one per-pixel class count.
- TUSER_WIDTH, 1, stream tuser width; only bit 0 (SOF) is used.
- SUM_WIDTH, 24, per-class frame accumulator width.
- Y_WIDTH, 12, line counter / height width.
- CLASS_WIDTH, 4, index width; must satisfy 2^CLASS_WIDTH >= NUM_CLASS.

Ports:
- reset  in  1  asynchronous, active-high reset.
- clk  in  1  single clock.
- cke  in  1  global clock enable; all state frozen when low.
- ctl_enable  in  1  1 = run; 0 = go idle.
- param_height  in  Y_WIDTH  lines per frame; must be >= 1.
- s_axi4s_tuser  in  TUSER_WIDTH  bit 0 = SOF.
- s_axi4s_tlast  in  1  end of line.
- s_axi4s_tcount  in  NUM_CLASS*COUNT_WIDTH  per-class counts, class i at [i*COUNT_WIDTH +: COUNT_WIDTH].
- s_axi4s_tvalid  in  1  beat valid.
- s_axi4s_tready  out  1  tied 1; the block never backpressures.
- m_class  out  CLASS_WIDTH  argmax class index.
- m_max  out  SUM_WIDTH  total of the winning class.
- m_sum  out  NUM_CLASS*SUM_WIDTH  all class totals.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted.
- stat_busy  out  1  main FSM not IDLE.
- stat_err_count  out  8  short-frame count; saturating.
- stat_drop_count  out  8  dropped-result count; saturating.

Behaviour:
- Reset values: all outputs and all state are 0, except s_axi4s_tready, which is 1. Reset is asynchronous and effective mid-frame or mid-scan.
- Beat accepted when cke && s_axi4s_tvalid.
- Main FSM:
  - IDLE -> WAIT_SOF when ctl_enable=1.
  - WAIT_SOF: beats without SOF are ignored. On an SOF beat -> ACCUM; sum[i] <= tcount[i]; line <= 0, or 1 if tlast is set on that beat.
  - ACCUM: every beat adds tcount[i] into sum[i]. Addition saturates at 2^SUM_WIDTH-1; no wrap.
  - ACCUM, tlast beat: line increments. If (line+1)==param_height, this is frame end: rslt[i] <= sum[i] + this beat's counts, the scan starts, and the FSM -> WAIT_SOF.
  - ACCUM, SOF before frame end (short frame): stat_err_count++; accumulation restarts from this beat, same as an SOF in WAIT_SOF.
  - param_height==1: the SOF beat with tlast is itself frame end.
  - ctl_enable=0 in any state: -> IDLE next cycle; the partial frame is discarded. The scan and any pending result are unaffected.
- Scan FSM (independent of main FSM):
  - S_IDLE -> S_SCAN at frame end: idx=0, best=rslt[0], class=0.
  - S_SCAN: one class per cycle. Strict greater-than compare, so ties resolve to the lowest index.
  - After class NUM_CLASS-1 -> S_OUT with m_valid=1.
  - m_valid rises exactly NUM_CLASS+1 accepted cycles after the frame-end beat.
  - S_OUT: m_class, m_max and m_sum hold stable until m_valid && m_ready, then -> S_IDLE. m_valid may not drop without m_ready.
  - Frame end while the scan FSM is not S_IDLE: the new result is discarded, stat_drop_count++, and the current scan/output is untouched.
- Frame end and m_ready in the same cycle while in S_OUT: counts as a drop. The handshake completes; no scan is started.
- cke=0 freezes both FSMs, both counters and the output regs. m_valid holds.

Decomposition:
- Package video_dnn_count_pkg holds:
  - main-state enum: IDLE, WAIT_SOF, ACCUM;
  - scan-state enum: S_IDLE, S_SCAN, S_OUT;
  - a saturating-add helper function.
- One natural sub-module, video_dnn_count_argmax_seq: the sequential scan over the rslt vector with its valid/ready output.

Test Plan:
- Height=2, width=4, every pixel count class3=5 and others 0 -> m_sum[3]=40, others 0; m_class=3; m_max=40; m_valid at frame-end+11 cycles.
- Classes 2 and 7 both total 16 -> m_class=2 (tie to lowest index).
- SOF injected after 1 of 2 lines, then a full frame -> stat_err_count=1; result equals only the full frame.
- m_ready held 0, then three tiny height=1 frames ending within the scan window -> stat_drop_count=2; first result stays stable; accepted when m_ready=1.
- SUM_WIDTH=8, 100 pixels with class0=7 -> m_sum[0]=255 (saturated).
- Assert reset mid-ACCUM and mid-S_OUT -> all outputs 0 immediately; the next full frame gives correct totals.
